io_port_bridge: RTL and testbench

Host-side counterpart of the load_store processor's I/O port. It buffers host words into an input FIFO and presents the head word on the processor's read_in. It also captures processor write_out words into an output FIFO that the host drains. Both host sides use a valid/ready handshake; the processor side uses single-cycle strobes.

---
 rtl/io_bridge_pkg.sv | 13 +
 rtl/sync_fifo.sv | 84 ++++++++
 rtl/io_port_bridge.sv | 138 +++++++++++++
 tb/tb_io_port_bridge.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared definitions for the host <-> processor I/O port bridge.
//   WIDTH_DEFAULT  : default data word width (matches processor read_in/write_out)
//   bridge_state_e : bridge control FSM encoding (RUN / FLUSH)
package io_bridge_pkg;

    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bridge_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with no fall-through. A pushed word becomes visible on dout
// after the push edge. dout reads as 0 while the FIFO is empty.
// Ports:
//   clock, rst   : rising-edge clock, asynchronous active-low reset
//   push, din    : write request and data (ignored when full unless popping too)
//   pop          : read request (ignored when empty)
//   flush        : empties the FIFO on the next edge; overrides push/pop
//   dout         : head word, 0 when empty
//   full, empty  : occupancy flags derived from the registered count
//   count        : number of stored words, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is only safe when a pop frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: its contents are meaningless while count is 0.
    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/io_port_bridge.sv
// Host-side bridge for the load_store processor's I/O port.
// Host words are buffered in an input FIFO whose head drives read_in; processor
// write_out words are captured in an output FIFO that the host drains.
// Ports:
//   clock, rst                                 : clock, asynchronous active-low reset
//   host_in_data/valid/ready                   : host -> input FIFO (valid/ready)
//   host_out_data/valid/ready                  : output FIFO -> host (valid/ready)
//   read_in, in_avail, in_ack                  : input FIFO head to processor, pop strobe
//   write_out, out_we, out_space               : processor write strobe into output FIFO
//   err_overflow, err_underflow, clr_err       : sticky error flags and their clear;
//                                                clr_err held 2+ cycles flushes both FIFOs
module io_port_bridge
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    output logic [WIDTH-1:0] read_in,
    output logic             in_avail,
    input  logic             in_ack,
    input  logic [WIDTH-1:0] write_out,
    input  logic             out_we,
    output logic             out_space,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             clr_err
);

    bridge_state_e state_q, state_d;
    logic          clr_hold_q, clr_hold_d;
    logic          err_overflow_q, err_overflow_d;
    logic          err_underflow_q, err_underflow_d;

    logic          in_full, in_empty, out_full, out_empty;
    logic [AW:0]   in_count, out_count;
    logic          in_push, in_pop, out_push, out_pop;
    logic          flush;
    logic          unused_counts;

    // Fill levels are not needed at this level; the flags carry all decisions.
    assign unused_counts = ^{in_count, out_count};

    // Input path: a pop at full frees a slot for a host push on the same edge.
    // Ready is held low in reset and during the flush cycle so no word is lost.
    assign in_pop        = in_ack && !in_empty;
    assign host_in_ready = rst && (state_q == ST_RUN) && (!in_full || in_pop);
    assign in_push       = host_in_valid && host_in_ready;
    assign in_avail      = !in_empty;

    // Output path: space is judged on registered occupancy only, so a write
    // at full is dropped even if the host pops on the same edge.
    assign out_space      = rst && !out_full;
    assign out_push       = out_we && !out_full;
    assign host_out_valid = !out_empty;
    assign out_pop        = host_out_valid && host_out_ready;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (in_push),
        .pop   (in_pop),
        .flush (flush),
        .din   (host_in_data),
        .dout  (read_in),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (out_push),
        .pop   (out_pop),
        .flush (flush),
        .din   (write_out),
        .dout  (host_out_data),
        .full  (out_full),
        .empty (out_empty),
        .count (out_count)
    );

    // A new error on the same edge as clr_err wins over the clear.
    always_comb begin
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        if (clr_err) begin
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end
        if (out_we && out_full)  err_overflow_d  = 1'b1;
        if (in_ack && in_empty)  err_underflow_d = 1'b1;
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

    // clr_hold_q remembers that clr_err was high last cycle, so a second
    // consecutive cycle is recognised as a flush request.
    assign clr_hold_d = clr_err;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_RUN;
            clr_hold_q      <= 1'b0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            clr_hold_q      <= clr_hold_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (clr_err && clr_hold_q) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        flush = (state_q == ST_FLUSH);
    end

endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] host_in_data;
    logic             host_in_valid;
    logic             host_in_ready;
    logic [WIDTH-1:0] host_out_data;
    logic             host_out_valid;
    logic             host_out_ready;
    logic [WIDTH-1:0] read_in;
    logic             in_avail;
    logic             in_ack;
    logic [WIDTH-1:0] write_out;
    logic             out_we;
    logic             out_space;
    logic             err_overflow;
    logic             err_underflow;
    logic             clr_err;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    io_port_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .rst            (rst),
        .host_in_data   (host_in_data),
        .host_in_valid  (host_in_valid),
        .host_in_ready  (host_in_ready),
        .host_out_data  (host_out_data),
        .host_out_valid (host_out_valid),
        .host_out_ready (host_out_ready),
        .read_in        (read_in),
        .in_avail       (in_avail),
        .in_ack         (in_ack),
        .write_out      (write_out),
        .out_we         (out_we),
        .out_space      (out_space),
        .err_overflow   (err_overflow),
        .err_underflow  (err_underflow),
        .clr_err        (clr_err)
    );

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        host_in_data = '0; host_in_valid = 1'b0; host_out_ready = 1'b0;
        in_ack = 1'b0; write_out = '0; out_we = 1'b0; clr_err = 1'b0;
        #1 rst = 1'b0;
        tick; tick;
        checks++; if (read_in !== 16'h0) begin failures++; $display("[TB] FAIL rst_read_in got=%h exp=0000", read_in); end
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_avail got=%b exp=0", in_avail); end
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", host_out_valid); end
        checks++; if (host_out_data !== 16'h0) begin failures++; $display("[TB] FAIL rst_out_data got=%h exp=0000", host_out_data); end
        checks++; if (out_space !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_space got=%b exp=0", out_space); end
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready got=%b exp=0", host_in_ready); end
        checks++; if ({err_overflow, err_underflow} !== 2'b00) begin failures++; $display("[TB] FAIL rst_errs got=%b%b exp=00", err_overflow, err_underflow); end
        rst = 1'b1;
        tick;
        checks++; if (host_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rel_in_ready got=%b exp=1", host_in_ready); end
        checks++; if (out_space !== 1'b1) begin failures++; $display("[TB] FAIL rel_out_space got=%b exp=1", out_space); end
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL rel_in_avail got=%b exp=0", in_avail); end
        checks++; if ({err_overflow, err_underflow} !== 2'b00) begin failures++; $display("[TB] FAIL rel_errs got=%b%b exp=00", err_overflow, err_underflow); end
    endtask

    task automatic test_input_basic;
        host_in_valid = 1'b1; host_in_data = 16'h13b0;
        tick;
        checks++; if (in_avail !== 1'b1) begin failures++; $display("[TB] FAIL in_lat_avail got=%b exp=1", in_avail); end
        checks++; if (read_in !== 16'h13b0) begin failures++; $display("[TB] FAIL in_lat_data got=%h exp=13b0", read_in); end
        host_in_data = 16'h1234;
        tick;
        host_in_valid = 1'b0;
        checks++; if (read_in !== 16'h13b0) begin failures++; $display("[TB] FAIL in_head_hold got=%h exp=13b0", read_in); end
        in_ack = 1'b1;
        tick;
        checks++; if (read_in !== 16'h1234) begin failures++; $display("[TB] FAIL in_pop1 got=%h exp=1234", read_in); end
        tick;
        in_ack = 1'b0;
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL in_pop2_avail got=%b exp=0", in_avail); end
        checks++; if (read_in !== 16'h0) begin failures++; $display("[TB] FAIL in_pop2_data got=%h exp=0000", read_in); end
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL in_no_underflow got=%b exp=0", err_underflow); end
    endtask

    task automatic test_fill_input;
        logic [WIDTH-1:0] exp_order [4];
        exp_order[0] = 16'h0002; exp_order[1] = 16'h0003;
        exp_order[2] = 16'h0004; exp_order[3] = 16'h0005;
        host_in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            host_in_data = WIDTH'(i);
            tick;
        end
        host_in_data = 16'h0005;
        #1;
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_ready_low got=%b exp=0", host_in_ready); end
        tick;
        checks++; if (read_in !== 16'h0001) begin failures++; $display("[TB] FAIL fill_head got=%h exp=0001", read_in); end
        in_ack = 1'b1;
        #1;
        checks++; if (host_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_pop_ready got=%b exp=1", host_in_ready); end
        tick;
        in_ack = 1'b0; host_in_valid = 1'b0;
        #1;
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL fill_still_full got=%b exp=0", host_in_ready); end
        in_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (read_in !== exp_order[i]) begin failures++; $display("[TB] FAIL fill_order%0d got=%h exp=%h", i, read_in, exp_order[i]); end
            tick;
        end
        in_ack = 1'b0;
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL fill_drained got=%b exp=0", in_avail); end
    endtask

    task automatic test_output;
        out_we = 1'b1; write_out = 16'h000b;
        tick;
        checks++; if (host_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL out_lat_valid got=%b exp=1", host_out_valid); end
        checks++; if (host_out_data !== 16'h000b) begin failures++; $display("[TB] FAIL out_lat_data got=%h exp=000b", host_out_data); end
        write_out = 16'h0003;
        tick;
        out_we = 1'b0;
        checks++; if (host_out_data !== 16'h000b) begin failures++; $display("[TB] FAIL out_head_hold got=%h exp=000b", host_out_data); end
        host_out_ready = 1'b1;
        tick;
        checks++; if (host_out_data !== 16'h0003) begin failures++; $display("[TB] FAIL out_pop1 got=%h exp=0003", host_out_data); end
        tick;
        host_out_ready = 1'b0;
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL out_empty_valid got=%b exp=0", host_out_valid); end
        checks++; if (host_out_data !== 16'h0) begin failures++; $display("[TB] FAIL out_empty_data got=%h exp=0000", host_out_data); end
    endtask

    task automatic test_errors_and_flush;
        out_we = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            write_out = 16'h00a0 + WIDTH'(i);
            tick;
        end
        out_we = 1'b0;
        checks++; if (out_space !== 1'b0) begin failures++; $display("[TB] FAIL ovf_full_space got=%b exp=0", out_space); end
        // Write at full while the host pops: the write must still be dropped.
        out_we = 1'b1; write_out = 16'hdead; host_out_ready = 1'b1;
        tick;
        out_we = 1'b0; host_out_ready = 1'b0;
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_flag got=%b exp=1", err_overflow); end
        checks++; if (host_out_data !== 16'h00a2) begin failures++; $display("[TB] FAIL ovf_head got=%h exp=00a2", host_out_data); end
        checks++; if (out_space !== 1'b1) begin failures++; $display("[TB] FAIL ovf_dropped got=%b exp=1", out_space); end
        in_ack = 1'b1;
        tick;
        in_ack = 1'b0;
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("[TB] FAIL udf_flag got=%b exp=1", err_underflow); end
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL udf_avail got=%b exp=0", in_avail); end
        host_in_valid = 1'b1; host_in_data = 16'h00c1;
        tick;
        host_in_data = 16'h00c2;
        tick;
        host_in_valid = 1'b0;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        checks++; if ({err_overflow, err_underflow} !== 2'b00) begin failures++; $display("[TB] FAIL clr_flags got=%b%b exp=00", err_overflow, err_underflow); end
        checks++; if (read_in !== 16'h00c1) begin failures++; $display("[TB] FAIL clr_in_kept got=%h exp=00c1", read_in); end
        checks++; if (host_out_data !== 16'h00a2) begin failures++; $display("[TB] FAIL clr_out_kept got=%h exp=00a2", host_out_data); end
        tick;
        checks++; if (in_avail !== 1'b1) begin failures++; $display("[TB] FAIL clr_no_flush got=%b exp=1", in_avail); end
        clr_err = 1'b1;
        tick; tick;
        clr_err = 1'b0;
        checks++; if (in_avail !== 1'b1) begin failures++; $display("[TB] FAIL flush_pending got=%b exp=1", in_avail); end
        tick;
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL flush_in got=%b exp=0", in_avail); end
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out got=%b exp=0", host_out_valid); end
        checks++; if (read_in !== 16'h0) begin failures++; $display("[TB] FAIL flush_read_in got=%h exp=0000", read_in); end
        checks++; if (host_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_run_ready got=%b exp=1", host_in_ready); end
        checks++; if (out_space !== 1'b1) begin failures++; $display("[TB] FAIL flush_space got=%b exp=1", out_space); end
    endtask

    task automatic test_set_wins;
        in_ack = 1'b1; clr_err = 1'b1;
        tick;
        in_ack = 1'b0; clr_err = 1'b0;
        checks++; if (err_underflow !== 1'b1) begin failures++; $display("[TB] FAIL setwin_flag got=%b exp=1", err_underflow); end
        tick;
        clr_err = 1'b1;
        tick;
        clr_err = 1'b0;
        checks++; if (err_underflow !== 1'b0) begin failures++; $display("[TB] FAIL setwin_clear got=%b exp=0", err_underflow); end
    endtask

    task automatic test_reset_mid;
        host_in_valid = 1'b1; out_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_in_data = 16'h0d01 + WIDTH'(i);
            write_out    = 16'h0e01 + WIDTH'(i);
            tick;
        end
        host_in_valid = 1'b0; out_we = 1'b0;
        checks++; if ({in_avail, host_out_valid} !== 2'b11) begin failures++; $display("[TB] FAIL mid_pre got=%b%b exp=11", in_avail, host_out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++; if (in_avail !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_in got=%b exp=0", in_avail); end
        checks++; if (host_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_out got=%b exp=0", host_out_valid); end
        checks++; if (read_in !== 16'h0) begin failures++; $display("[TB] FAIL mid_async_data got=%h exp=0000", read_in); end
        checks++; if (host_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_async_ready got=%b exp=0", host_in_ready); end
        tick;
        #2 rst = 1'b1;
        tick;
        checks++; if ({in_avail, host_out_valid} !== 2'b00) begin failures++; $display("[TB] FAIL mid_after got=%b%b exp=00", in_avail, host_out_valid); end
        checks++; if ({host_in_ready, out_space} !== 2'b11) begin failures++; $display("[TB] FAIL mid_after_rdy got=%b%b exp=11", host_in_ready, out_space); end
    endtask

    initial begin
        test_reset;
        test_input_basic;
        test_fill_input;
        test_output;
        test_errors_and_flush;
        test_set_wins;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
